// File: rtl/tenkey_scan.sv
// Ten-key front-end: synchronises, debounces and de-duplicates raw key lines into one-hot strobes.
// Define TENKEY_AUTOREPEAT_EN to add periodic repeat strobes while a key stays held.
module tenkey_scan #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] sw,
   output logic [9:0] tenkey,
   output logic [3:0] key_code,
   output logic       busy,
   output logic       multi_err
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
       REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
      $error("tenkey_scan: parameter out of legal range");
   end

   state_t     state, state_next;
   logic [9:0] s1, s2, cand, cand_next, tenkey_next;
   logic [7:0] cnt, cnt_next;
   logic [3:0] key_code_next;
   logic       one_hot, multi_hot;

   function automatic logic [3:0] encode(input logic [9:0] v);
      logic [3:0] code;
      code = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (v[i]) code = 4'(i);
      end
      return code;
   endfunction

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi_hot = (s2 & (s2 - 10'd1)) != 10'd0;
   assign one_hot   = (s2 != 10'd0) && !multi_hot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (one_hot) state_next = DEBOUNCE;
         DEBOUNCE: begin
            if (s2 != cand)          state_next = IDLE;
            else if (cnt == DB_LAST) state_next = PRESSED;
         end
         PRESSED:  if (s2 == 10'd0) state_next = RELEASE;
         RELEASE: begin
            if (s2 != 10'd0)         state_next = PRESSED;
            else if (cnt == DB_LAST) state_next = IDLE;
         end
         default:  state_next = IDLE;
      endcase
   end

`ifdef TENKEY_AUTOREPEAT_EN
   localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
   logic [15:0] rep, rep_next;
`endif

   always_comb begin
      cand_next     = cand;
      tenkey_next   = '0;
      key_code_next = key_code;
      cnt_next      = cnt;
      if (state_next != state) begin
         cnt_next = (state_next == DEBOUNCE || state_next == RELEASE) ? 8'd1 : 8'd0;
      end else if (state == DEBOUNCE || state == RELEASE) begin
         cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      end
      if (state == IDLE && one_hot) cand_next = s2;
      if (state == DEBOUNCE && s2 == cand && cnt == DB_LAST) begin
         tenkey_next   = cand;
         key_code_next = encode(cand);
      end
`ifdef TENKEY_AUTOREPEAT_EN
      // Only a steady hold of the accepted key advances the repeat timer.
      rep_next = '0;
      if (state == PRESSED && s2 == cand) begin
         if (rep == REP_LAST) tenkey_next = cand;
         else                 rep_next    = rep + 16'd1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand      <= '0;
         cnt       <= '0;
         tenkey    <= '0;
         key_code  <= 4'hF;
         busy      <= 1'b0;
         multi_err <= 1'b0;
`ifdef TENKEY_AUTOREPEAT_EN
         rep       <= '0;
`endif
      end else begin
         cand      <= cand_next;
         cnt       <= cnt_next;
         tenkey    <= tenkey_next;
         key_code  <= key_code_next;
         busy      <= (state_next != IDLE);
         multi_err <= (state == IDLE) && multi_hot;
`ifdef TENKEY_AUTOREPEAT_EN
         rep       <= rep_next;
`endif
      end
   end

endmodule

// File: tb/tb_tenkey_scan.sv
// Self-checking bench for tenkey_scan: directed keypad scenarios plus random key traffic
// compared cycle by cycle against a run-length reference model (honours TENKEY_AUTOREPEAT_EN).
module tb_tenkey_scan;

   localparam int D = 4;
   localparam int R = 16;

   logic       clk;
   logic       rst_n;
   logic [9:0] sw;
   logic [9:0] tenkey;
   logic [3:0] key_code;
   logic       busy;
   logic       multi_err;

   int checks = 0;
   int passes = 0;
   int strobes = 0;

   // Reference model: a key is accepted after D identical one-hot samples seen from rest,
   // and the pad is free again only after D consecutive all-zero samples.
   logic [9:0] m_s1, m_s2, m_key;
   bit         m_locked;
   int         m_run, m_rep;
   logic [9:0] exp_tenkey;
   logic [3:0] exp_code;
   logic       exp_busy, exp_multi;

   tenkey_scan #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .tenkey    (tenkey),
      .key_code  (key_code),
      .busy      (busy),
      .multi_err (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
   endtask

   task automatic modelReset();
      m_s1 = '0; m_s2 = '0; m_key = '0;
      m_locked = 0; m_run = 0; m_rep = 0;
      exp_tenkey = '0; exp_code = 4'hF; exp_busy = 0; exp_multi = 0;
   endtask

   function automatic logic [3:0] indexOf(input logic [9:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 10; i++) if (v[i]) idx = 4'(i);
      return idx;
   endfunction

   task automatic modelStep(input logic [9:0] raw);
      logic [9:0] s;
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      exp_tenkey = '0;
      exp_multi  = 0;
      if (!m_locked) begin
         if (m_run == 0) begin
            if ($countones(s) == 1) begin
               m_key = s;
               m_run = 1;
            end else if ($countones(s) >= 2) begin
               exp_multi = 1;
            end
         end else if (s == m_key) begin
            m_run++;
            if (m_run == D) begin
               exp_tenkey = m_key;
               exp_code   = indexOf(m_key);
               m_locked   = 1;
               m_run      = 0;
               m_rep      = 0;
            end
         end else begin
            m_run = 0;
         end
      end else if (s == 10'd0) begin
         m_run++;
         m_rep = 0;
         if (m_run == D) begin
            m_locked = 0;
            m_run    = 0;
         end
      end else begin
         m_run = 0;
`ifdef TENKEY_AUTOREPEAT_EN
         if (s == m_key) begin
            m_rep++;
            if (m_rep == R) begin
               exp_tenkey = m_key;
               m_rep      = 0;
            end
         end else begin
            m_rep = 0;
         end
`endif
      end
      exp_busy = m_locked || (m_run != 0);
   endtask

   task automatic applyStimulus(input logic [9:0] value, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         sw = value;
         @(posedge clk);
         modelStep(sw);
         @(negedge clk);
         checkOutput("tenkey", tenkey, exp_tenkey);
         checkOutput("key_code", key_code, exp_code);
         checkOutput("busy", busy, exp_busy);
         checkOutput("multi_err", multi_err, exp_multi);
         if (tenkey != 10'd0) strobes++;
      end
   endtask

   initial begin
      int exp_single;
      int kind, len, a, b;
      logic [9:0] v;

      rst_n = 1'b0;
      sw    = '0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_tenkey", tenkey, 10'd0);
      checkOutput("rst_code", key_code, 4'hF);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_multi", multi_err, 1'b0);
      rst_n = 1'b1;
      applyStimulus(10'd0, 4);

      // Single press of 7
`ifdef TENKEY_AUTOREPEAT_EN
      exp_single = 2;
`else
      exp_single = 1;
`endif
      strobes = 0;
      applyStimulus(10'b0010000000, 20);
      applyStimulus(10'd0, 10);
      checkOutput("single_strobes", 16'(strobes), 16'(exp_single));
      checkOutput("single_code", key_code, 4'd7);

      // Bouncing key 3, then a clean hold
      strobes = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(10'b0000001000, 2);
         applyStimulus(10'd0, 2);
      end
      checkOutput("bounce_quiet", 16'(strobes), 16'd0);
      applyStimulus(10'b0000001000, 10);
      applyStimulus(10'd0, 10);
      checkOutput("bounce_strobes", 16'(strobes), 16'd1);
      checkOutput("bounce_code", key_code, 4'd3);

      // Two keys at once
      strobes = 0;
      applyStimulus(10'b0000000011, 10);
      checkOutput("multi_flag", multi_err, 1'b1);
      checkOutput("multi_busy", busy, 1'b0);
      applyStimulus(10'd0, 6);
      checkOutput("multi_strobes", 16'(strobes), 16'd0);

      // Rollover: 7, then 7+3, then 3 alone, then full release and a fresh 3
      strobes = 0;
      applyStimulus(10'b0010000000, 10);
      applyStimulus(10'b0010001000, 5);
      applyStimulus(10'b0000001000, 5);
      applyStimulus(10'd0, 10);
      checkOutput("roll_strobes", 16'(strobes), 16'd1);
      checkOutput("roll_code", key_code, 4'd7);
      applyStimulus(10'b0000001000, 10);
      applyStimulus(10'd0, 10);
      checkOutput("roll_code3", key_code, 4'd3);

      // Reset in the middle of debouncing key 5, key kept held through reset
      strobes = 0;
      applyStimulus(10'b0000100000, 3);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("midrst_tenkey", tenkey, 10'd0);
      checkOutput("midrst_code", key_code, 4'hF);
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_multi", multi_err, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(10'b0000100000, 10);
      checkOutput("midrst_strobes", 16'(strobes), 16'd1);
      checkOutput("midrst_code5", key_code, 4'd5);
      applyStimulus(10'd0, 10);

`ifdef TENKEY_AUTOREPEAT_EN
      strobes = 0;
      applyStimulus(10'b1000000000, 60);
      checkOutput("repeat_strobes", 16'(strobes), 16'd4);
      checkOutput("repeat_code", key_code, 4'd9);
      applyStimulus(10'd0, 10);
`endif

      // Random key traffic
      for (int seg = 0; seg < 150; seg++) begin
         kind = int'($urandom_range(0, 3));
         len  = int'($urandom_range(1, 12));
         a    = int'($urandom_range(0, 9));
         b    = (a + int'($urandom_range(1, 9))) % 10;
         case (kind)
            0:       v = 10'd0;
            1:       v = 10'd1 << a;
            2:       v = (10'd1 << a) | (10'd1 << b);
            default: v = 10'($urandom_range(0, 1023));
         endcase
         applyStimulus(v, len);
      end
      applyStimulus(10'd0, 10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/tenkey_scan.md
# tenkey_scan

Keypad front-end that drives the 10-bit one-hot `tenkey` bus consumed by the electronic-lock core. Samples ten raw, bouncing, asynchronous push-button lines, synchronises and debounces them, rejects multi-key presses, and emits exactly one single-cycle one-hot strobe per accepted keystroke. It is the transmitting end of the tenkey interface: everything it emits is guaranteed one-hot or all-zero, so the downstream key encoder never sees an undefined code.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples required to accept a press or a release. Legal range 2..255.
- `REPEAT_CYCLES`, default 16: hold period between auto-repeat strobes. Only used with `TENKEY_AUTOREPEAT_EN`. Legal range 2..65535.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sw`  in  10: raw key lines, active high, asynchronous to `clk`. Bit n is digit n.
- `tenkey`  out  10: one-hot key strobe, high for exactly one cycle per accepted press; otherwise 0.
- `key_code`  out  4: binary digit 0..9 of the last accepted key; holds between presses.
- `busy`  out  1: high while a key is debouncing, held, or releasing, i.e. state != IDLE.
- `multi_err`  out  1: high in any IDLE cycle where the synchronised input has two or more bits set.

## Operation
- Input path: two-flop synchroniser on all 10 bits (`s1` then `s2`). All decisions use `s2`.
- Counter `cnt` is 8 bits wide and saturates. It is cleared on every state entry.
- Reset values: state IDLE, `s1`/`s2`/`cand` = 0, `tenkey` = 0, `key_code` = 4'hF, `busy` = 0, `multi_err` = 0.

FSM:
- **IDLE**
  - `s2` == 0: stay.
  - `s2` exactly one-hot: `cand` <= `s2`, `cnt` <= 1, go to DEBOUNCE.
  - `s2` multi-hot: stay, `multi_err` = 1.
- **DEBOUNCE**
  - `s2` != `cand`: go to IDLE. No strobe.
  - `s2` == `cand` and `cnt` == `DEBOUNCE_CYCLES`-1: `tenkey` <= `cand` (one cycle), `key_code` <= encode(`cand`), go to PRESSED.
  - Otherwise: `cnt`++.
- **PRESSED**
  - `s2` == 0: `cnt` <= 1, go to RELEASE.
  - Any other value, including extra keys or a different key: stay. No strobe. Rollover is blocked until a full release.
- **RELEASE**
  - `s2` != 0: go to PRESSED. No strobe.
  - `s2` == 0 and `cnt` == `DEBOUNCE_CYCLES`-1: go to IDLE.
  - Otherwise: `cnt`++.

Output rules:
- `tenkey` is registered and defaults to 0 every cycle unless loaded as above. It is never multi-hot.
- `busy` and `multi_err` are registered from next-state and next-input.

## Timing
- Edge 0 is the first rising edge that samples `sw` stable and one-hot.
  - `s2` is valid after edge 1.
  - IDLE captures at edge 2.
  - The strobe is loaded at edge `DEBOUNCE_CYCLES`+1 and is visible for the following cycle only. With the default of 4, `tenkey` is high between edges 5 and 6.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised samples produces no strobe.
- Minimum press-to-press spacing is about 2×`DEBOUNCE_CYCLES`+3 cycles.
- When `rst_n` is asserted mid-operation, all state clears immediately and any in-flight strobe is dropped.
  - After deassertion, a key already held starts a fresh debounce from IDLE and produces a strobe.
- A simultaneous release and new press inside one sample resolves as "not zero" and stays in PRESSED.

## Configuration
- `TENKEY_AUTOREPEAT_EN` undefined:
  - One strobe per press, regardless of hold time.
  - The repeat counter is not built.
- `TENKEY_AUTOREPEAT_EN` defined:
  - Adds a 16-bit repeat counter, cleared on entry to PRESSED and whenever `s2` != `cand`.
  - While in PRESSED with `s2` == `cand`, the counter increments.
  - When it reaches `REPEAT_CYCLES`-1, `tenkey` <= `cand` for one cycle and the counter restarts at 0.
  - `key_code` is unchanged by repeats.

## Test plan
- **Single press:** reset, hold `sw`=10'b0010000000 for 20 cycles, then release.
  - Exactly one `tenkey`=10'b0010000000 pulse, visible after edge 5.
  - `key_code`=7.
  - `busy` returns low 4+ cycles after release.
- **Bounce:** toggle `sw`[3] 1/0 every 2 cycles for 12 cycles, then hold for 10 cycles.
  - No strobe during toggling.
  - One 10'b0000001000 strobe after the hold stabilises.
  - `key_code`=3.
- **Multi-key:** `sw`=10'b0000000011 held for 10 cycles.
  - `multi_err`=1 from edge 2 onward.
  - `tenkey` stays 0.
  - `busy`=0.
- **Rollover:** press 7 and hold, add 3, release 7, release 3.
  - Only the 7 strobe appears.
  - No 3 strobe until a full release followed by a new press of 3.
- **Reset mid-debounce:** assert `rst_n`=0 at edge 3 of a press of 5, then deassert.
  - Outputs return to reset values immediately.
  - One 10'b0000100000 strobe appears 5 edges after deassert while `sw` is still held.
- **Auto-repeat (`TENKEY_AUTOREPEAT_EN`):** hold 9 for 60 cycles with defaults.
  - Strobe at edge 5, then every 16 cycles (edges 21, 37, 53).
  - `key_code`=9 throughout.
